// File: rtl/dadda_seq_mult_8x8_pkg.sv
// -----------------------------------------------------------------------------
// dadda_seq_pkg
// Shared types and constants for the sequenced 8x8 multiplier built on the
// 4x4 Dadda core.
//   state_t    : controller states (IDLE, CALC, DONE)
//   step_t     : 2-bit partial-product index
//   STEP_LAST  : index of the final partial product
//   step_shift : left-shift applied to each nibble product before accumulation
// -----------------------------------------------------------------------------
package dadda_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    localparam step_t      STEP_LAST = 2'd3;
    localparam logic [3:0] SHIFT_S0  = 4'd0;
    localparam logic [3:0] SHIFT_S1  = 4'd4;
    localparam logic [3:0] SHIFT_S2  = 4'd4;
    localparam logic [3:0] SHIFT_S3  = 4'd8;

    // Weight of each nibble product: lo*lo, lo*hi, hi*lo, hi*hi.
    function automatic logic [3:0] step_shift(input step_t s);
        logic [3:0] sh;
        case (s)
            2'd0:    sh = SHIFT_S0;
            2'd1:    sh = SHIFT_S1;
            2'd2:    sh = SHIFT_S2;
            default: sh = SHIFT_S3;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/dadda_seq_mult_8x8_core.sv
// -----------------------------------------------------------------------------
// Dadda_Multiplier_4x4
// Combinational 4x4 unsigned multiplier using a Dadda reduction tree
// (column heights 4 -> 3 -> 2) followed by a final two-row adder.
//   A       : in  4  multiplicand
//   B       : in  4  multiplier
//   Product : out 8  A*B
// -----------------------------------------------------------------------------
module Dadda_Multiplier_4x4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] Product
);

    logic [3:0] w_pp [4];
    logic w_s1, w_c1, w_s2, w_c2, w_s3, w_c3;
    logic w_s4, w_c4, w_s5, w_c5, w_s6, w_c6;
    logic [7:0] w_row0, w_row1;

    // w_pp[i][j] = A[i] & B[j], weight i+j
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                w_pp[i][j] = A[i] & B[j];
            end
        end
    end

    // Stage 1: bring max column height from 4 down to 3 (columns 3 and 4)
    assign {w_c1, w_s1} = {1'b0, w_pp[0][3]} + {1'b0, w_pp[1][2]};
    assign {w_c2, w_s2} = {1'b0, w_pp[1][3]} + {1'b0, w_pp[2][2]};

    // Stage 2: bring every column down to 2
    assign {w_c3, w_s3} = {1'b0, w_pp[0][2]} + {1'b0, w_pp[1][1]};
    assign {w_c4, w_s4} = {1'b0, w_s1} + {1'b0, w_pp[2][1]} + {1'b0, w_pp[3][0]};
    assign {w_c5, w_s5} = {1'b0, w_s2} + {1'b0, w_pp[3][1]} + {1'b0, w_c1};
    assign {w_c6, w_s6} = {1'b0, w_pp[2][3]} + {1'b0, w_pp[3][2]} + {1'b0, w_c2};

    // Final carry-propagate add of the two remaining rows
    assign w_row0 = {1'b0, w_pp[3][3], w_s6, w_s5, w_s4, w_s3, w_pp[0][1], w_pp[0][0]};
    assign w_row1 = {1'b0, w_c6, w_c5, w_c4, w_c3, w_pp[2][0], w_pp[1][0], 1'b0};
    assign Product = w_row0 + w_row1;

endmodule

// File: rtl/dadda_seq_mult_8x8.sv
// -----------------------------------------------------------------------------
// dadda_seq_mult_8x8
// 8x8 unsigned multiplier that time-shares one 4x4 Dadda core over four
// cycles, accumulating the nibble products into a 16-bit result.
//   clk       : in   1  clock, rising edge
//   rst       : in   1  synchronous active-high reset
//   in_valid  : in   1  A/B valid
//   in_ready  : out  1  ready to accept operands (IDLE)
//   A, B      : in   8  unsigned operands
//   out_valid : out  1  Product holds a completed result (DONE)
//   out_ready : in   1  consumer takes the result
//   Product   : out 16  accumulator; A*B while out_valid
//   busy      : out  1  CALC or DONE
// -----------------------------------------------------------------------------
module dadda_seq_mult_8x8
    import dadda_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Product,
    output logic        busy
);

    state_t      r_state;
    step_t       r_step;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;

    logic [3:0]  w_core_a;
    logic [3:0]  w_core_b;
    logic [7:0]  w_core_p;
    logic [15:0] w_pp_ext;

    // step[1] picks the high nibble of a, step[0] the high nibble of b,
    // giving the order lo*lo, lo*hi, hi*lo, hi*hi.
    assign w_core_a = r_step[1] ? r_a[7:4] : r_a[3:0];
    assign w_core_b = r_step[0] ? r_b[7:4] : r_b[3:0];

    Dadda_Multiplier_4x4 u_core (
        .A       (w_core_a),
        .B       (w_core_b),
        .Product (w_core_p)
    );

    assign w_pp_ext = {8'h00, w_core_p} << step_shift(r_step);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_acc   <= '0;
                        r_step  <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    // Max result 0xFE01 fits in 16 bits; no carry-out needed.
                    r_acc  <= r_acc + w_pp_ext;
                    r_step <= r_step + 2'd1;
                    if (r_step == STEP_LAST) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode from the state register only.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == CALC) || (r_state == DONE);
    assign Product   = r_acc;

endmodule

// File: tb/tb_dadda_seq_mult_8x8.sv
module tb_dadda_seq_mult_8x8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  A = 8'h00;
    logic [7:0]  B = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] Product;
    logic        busy;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dadda_seq_mult_8x8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Product   (Product),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: present operands, wait (bounded) for acceptance,
    // scramble inputs afterwards, check latency/result, hold out_ready low for
    // 'hold' cycles, then complete the output handshake.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                          input bit fixed_junk, input logic [7:0] junk, input string tag);
        logic [15:0] exp_p;
        bit          acc;
        exp_p = 16'(a) * 16'(b);
        A = a;
        B = b;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int w = 0; w < 20 && !acc; w++) begin
            acc = in_ready;
            tick();
        end
        if (!acc) begin
            chk({tag, "_accept_timeout"}, 16'h0, 16'h1);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            A = fixed_junk ? junk : 8'($urandom);
            B = fixed_junk ? junk : 8'($urandom);
            chk({tag, "_ov_low"}, 16'(out_valid), 16'h0);
            chk({tag, "_busy_calc"}, 16'(busy), 16'h1);
            tick();
        end
        // Four cycles after acceptance the result is presented.
        chk({tag, "_ov_high"}, 16'(out_valid), 16'h1);
        chk({tag, "_product"}, Product, exp_p);
        for (int h = 0; h < hold; h++) begin
            A = fixed_junk ? junk : 8'($urandom);
            B = fixed_junk ? junk : 8'($urandom);
            in_valid = 1'b1;
            tick();
            chk({tag, "_hold_ov"}, 16'(out_valid), 16'h1);
            chk({tag, "_hold_prod"}, Product, exp_p);
            chk({tag, "_hold_inrdy"}, 16'(in_ready), 16'h0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, 16'(in_ready), 16'h1);
        chk({tag, "_ov_drop"}, 16'(out_valid), 16'h0);
        chk({tag, "_prod_kept"}, Product, exp_p);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_inrdy", 16'(in_ready), 16'h1);
        chk("rst_ov", 16'(out_valid), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_prod", Product, 16'h0000);

        run_op(8'h00, 8'h00, 0, 1'b0, 8'h00, "zero");
        run_op(8'hFF, 8'hFF, 0, 1'b0, 8'h00, "max");

        // Back-to-back: second operand presented right after the handshake
        run_op(8'h12, 8'h34, 0, 1'b0, 8'h00, "b2b_a");
        chk("b2b_a_val", Product, 16'h03A8);
        run_op(8'hA5, 8'h3C, 0, 1'b0, 8'h00, "b2b_b");
        chk("b2b_b_val", Product, 16'h26AC);

        // Stall with inputs forced to 0xFF
        run_op(8'h0F, 8'hF0, 10, 1'b1, 8'hFF, "stall");
        chk("stall_val", Product, 16'h0E10);

        // Reset in the second CALC cycle discards the operation
        A = 8'h37;
        B = 8'h29;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mrst_busy0", 16'(busy), 16'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_inrdy", 16'(in_ready), 16'h1);
        chk("mrst_ov", 16'(out_valid), 16'h0);
        chk("mrst_busy", 16'(busy), 16'h0);
        chk("mrst_prod", Product, 16'h0000);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mrst_no_ov", 16'(out_valid), 16'h0);
        end
        run_op(8'h37, 8'h29, 0, 1'b0, 8'h00, "reissue");
        chk("reissue_val", Product, 16'h08CF);

        // Randomized operand pairs with random gaps and stalls, including
        // the corner operands folded in at the start
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n == 0) begin ra = 8'hFF; rb = 8'h01; end
            if (n == 1) begin ra = 8'h80; rb = 8'h80; end
            if (n == 2) begin ra = 8'hF0; rb = 8'h0F; end
            for (int g = 0; g < $urandom_range(0, 2); g++) tick();
            run_op(ra, rb, $urandom_range(0, 2), 1'b0, 8'h00, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
